bcd_seg_mux: RTL and testbench

Two-digit multiplexed seven-segment display driver that sits directly downstream of the 2-digit BCD counter. It consumes the counter's `tens`/`units` digits and time-multiplexes them onto one shared segment bus with per-digit anode enables. It inserts blanking slots between digits to suppress ghosting. It captures both digits once per frame so a counter update can never tear the displayed value.

---
 rtl/bcd_disp_pkg.sv | 25 ++
 rtl/bcd_seg_mux_if.sv | 27 ++
 rtl/bcd_to_seg7.sv | 33 +++
 rtl/bcd_seg_mux.sv | 136 +++++++++++++
 tb/tb_bcd_seg_mux.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bcd_disp_pkg.sv
// Shared types and segment constants for the multiplexed BCD display.
// Patterns are active-high {g,f,e,d,c,b,a}; bit 0 is segment a.
package bcd_disp_pkg;

  typedef enum logic [1:0] {
    BLANK_B,
    SHOW_UNITS,
    BLANK_A,
    SHOW_TENS
  } state_t;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/bcd_seg_mux_if.sv
// Digit inputs and display outputs of the segment multiplexer.
// master drives the digits; slave is the display driver.
interface bcd_seg_mux_if;

  logic [3:0] tens;
  logic [3:0] units;
  logic [6:0] seg;
  logic [1:0] an;
  logic       frame_tick;

  modport master (
    output tens,
    output units,
    input  seg,
    input  an,
    input  frame_tick
  );

  modport slave (
    input  tens,
    input  units,
    output seg,
    output an,
    output frame_tick
  );

endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
// Codes 10..15 show a dash; ACTIVE_LOW inverts the pattern.
module bcd_to_seg7
  import bcd_disp_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  logic [6:0] pat;

  always_comb begin
    pat = SEG_DASH;
    unique case (digit)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
  end

  assign seg = ACTIVE_LOW ? ~pat : pat;

endmodule

// File: rtl/bcd_seg_mux.sv
// Two-digit multiplexed seven-segment driver with blanking slots
// and a per-frame digit snapshot so a counter update never tears.
module bcd_seg_mux
  import bcd_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1,
  parameter bit LZ_BLANK       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  bcd_seg_mux_if.slave bus
);

  localparam int MAXN =
    (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW = $clog2(MAXN);

  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  localparam logic [6:0] SEG_IDLE =
    SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [1:0] AN_IDLE  =
    AN_ACTIVE_LOW ? 2'b11 : 2'b00;
  localparam logic [1:0] AN_UNITS =
    AN_ACTIVE_LOW ? 2'b10 : 2'b01;
  localparam logic [1:0] AN_TENS  =
    AN_ACTIVE_LOW ? 2'b01 : 2'b10;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic [3:0]    snap_t;
  logic [3:0]    snap_u;
  logic          show;
  logic          slot_end;
  logic          take;

  logic [3:0]    digit;
  logic [6:0]    pat;
  logic          lz_off;
  logic [6:0]    seg_d;
  logic [1:0]    an_d;
  logic          tick_d;
  logic [6:0]    seg_q;
  logic [1:0]    an_q;
  logic          tick_q;

  assign show     = (state == SHOW_UNITS) || (state == SHOW_TENS);
  assign slot_end = (cnt == (show ? SHOW_LAST : BLANK_LAST));
  assign take     = slot_end && (state == BLANK_B);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    if (slot_end) begin
      cnt_nx = '0;
      unique case (state)
        BLANK_B:    state_nx = SHOW_UNITS;
        SHOW_UNITS: state_nx = BLANK_A;
        BLANK_A:    state_nx = SHOW_TENS;
        SHOW_TENS:  state_nx = BLANK_B;
        default:    state_nx = BLANK_B;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BLANK_B;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // Digits are frozen for the whole frame at the start of SHOW_UNITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_t <= '0;
      snap_u <= '0;
    end else if (take) begin
      snap_t <= bus.tens;
      snap_u <= bus.units;
    end
  end

  assign digit  = (state == SHOW_TENS) ? snap_t : snap_u;
  assign lz_off = LZ_BLANK && (snap_t == 4'd0);

  bcd_to_seg7 #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_dec (
    .digit (digit),
    .seg   (pat)
  );

  always_comb begin
    seg_d  = SEG_IDLE;
    an_d   = AN_IDLE;
    tick_d = (state == SHOW_UNITS) && (cnt == '0);
    unique case (1'b1)
      (state == SHOW_UNITS): begin
        seg_d = pat;
        an_d  = AN_UNITS;
      end
      (state == SHOW_TENS) && !lz_off: begin
        seg_d = pat;
        an_d  = AN_TENS;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q  <= SEG_IDLE;
      an_q   <= AN_IDLE;
      tick_q <= 1'b0;
    end else begin
      seg_q  <= seg_d;
      an_q   <= an_d;
      tick_q <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_bcd_seg_mux.sv
// Directed bench for bcd_seg_mux: REFRESH_DIV=4, BLANK_CYCLES=1,
// active-low outputs, plus a leading-zero-blanking instance.
module tb_bcd_seg_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  bcd_seg_mux_if bus ();
  bcd_seg_mux_if lzb ();

  bcd_seg_mux #(
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1),
    .LZ_BLANK       (1'b0)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  bcd_seg_mux #(
    .REFRESH_DIV    (4),
    .BLANK_CYCLES   (1),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1),
    .LZ_BLANK       (1'b1)
  ) u_lz (
    .clk (clk),
    .rst (rst),
    .bus (lzb)
  );

  typedef struct {
    logic [3:0] tens;
    logic [3:0] units;
    logic [6:0] seg;
    logic [1:0] an;
    logic       tick;
  } vec_t;

  vec_t vecs [32];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic int outs(input logic [6:0] s,
                              input logic [1:0] a,
                              input logic t);
    return int'({s, a, t});
  endfunction

  task automatic row(input int k, input logic [3:0] t,
                     input logic [3:0] u, input logic [6:0] s,
                     input logic [1:0] a, input logic tk);
    vecs[k-1].tens  = t;
    vecs[k-1].units = u;
    vecs[k-1].seg   = s;
    vecs[k-1].an    = a;
    vecs[k-1].tick  = tk;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int last;
    int off;
    int ticks;
    bit found;

    // k = rising edge number after reset release
    row( 1,  4, 7, 7'h7F, 2'b11, 1'b0);
    row( 2,  4, 7, 7'h78, 2'b10, 1'b1);
    row( 3,  4, 7, 7'h78, 2'b10, 1'b0);
    row( 4,  4, 3, 7'h78, 2'b10, 1'b0);
    row( 5,  4, 3, 7'h78, 2'b10, 1'b0);
    row( 6,  4, 3, 7'h7F, 2'b11, 1'b0);
    row( 7,  4, 3, 7'h19, 2'b01, 1'b0);
    row( 8, 12, 3, 7'h19, 2'b01, 1'b0);
    row( 9, 12, 3, 7'h19, 2'b01, 1'b0);
    row(10, 12, 3, 7'h19, 2'b01, 1'b0);
    row(11, 12, 3, 7'h7F, 2'b11, 1'b0);
    row(12, 12, 3, 7'h30, 2'b10, 1'b1);
    row(13, 12, 3, 7'h30, 2'b10, 1'b0);
    row(14, 12, 3, 7'h30, 2'b10, 1'b0);
    row(15, 12, 3, 7'h30, 2'b10, 1'b0);
    row(16, 12, 3, 7'h7F, 2'b11, 1'b0);
    row(17, 12, 3, 7'h3F, 2'b01, 1'b0);
    row(18, 12, 3, 7'h3F, 2'b01, 1'b0);
    row(19, 12, 3, 7'h3F, 2'b01, 1'b0);
    row(20, 12, 3, 7'h3F, 2'b01, 1'b0);
    row(21,  2, 8, 7'h7F, 2'b11, 1'b0);
    row(22,  5, 5, 7'h00, 2'b10, 1'b1);
    row(23,  5, 5, 7'h00, 2'b10, 1'b0);
    row(24,  5, 5, 7'h00, 2'b10, 1'b0);
    row(25,  5, 5, 7'h00, 2'b10, 1'b0);
    row(26,  5, 5, 7'h7F, 2'b11, 1'b0);
    row(27,  5, 5, 7'h24, 2'b01, 1'b0);
    row(28,  5, 5, 7'h24, 2'b01, 1'b0);
    row(29,  5, 5, 7'h24, 2'b01, 1'b0);
    row(30,  5, 5, 7'h24, 2'b01, 1'b0);
    row(31,  5, 5, 7'h7F, 2'b11, 1'b0);
    row(32,  5, 5, 7'h12, 2'b10, 1'b1);

    bus.tens  = 4'd4;
    bus.units = 4'd7;
    lzb.tens  = 4'd0;
    lzb.units = 4'd5;
    rst       = 1'b1;

    repeat (3) begin
      @(negedge clk);
      chk("reset_main", outs(bus.seg, bus.an, bus.frame_tick),
          outs(7'h7F, 2'b11, 1'b0));
      chk("reset_lz", outs(lzb.seg, lzb.an, lzb.frame_tick),
          outs(7'h7F, 2'b11, 1'b0));
    end
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      bus.tens  = vecs[i].tens;
      bus.units = vecs[i].units;
      @(negedge clk);
      if (bus.seg !== vecs[i].seg || bus.an !== vecs[i].an ||
          bus.frame_tick !== vecs[i].tick) begin
        errors++;
        $display("FAIL vec_k%0d: got seg=%h an=%b tick=%b required seg=%h an=%b tick=%b",
                 i + 1, bus.seg, bus.an, bus.frame_tick,
                 vecs[i].seg, vecs[i].an, vecs[i].tick);
      end
      checks++;
    end

    // Frame period, blank slots and leading-zero instance
    cyc   = 32;
    last  = 32;
    off   = 0;
    ticks = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      cyc++;
      off = (off + 1) % 10;
      if (bus.frame_tick === 1'b1) begin
        chk("tick_interval", cyc - last, 10);
        last = cyc;
        ticks++;
      end
      if (off < 4)
        chk("an_units", int'(bus.an), int'(2'b10));
      else if (off == 4 || off == 9)
        chk("an_blank", int'(bus.an), int'(2'b11));
      else
        chk("an_tens", int'(bus.an), int'(2'b01));
      if (off < 4)
        chk("lz_units", outs(lzb.seg, lzb.an, lzb.frame_tick),
            outs(7'h12, 2'b10, off == 0));
      else
        chk("lz_off", outs(lzb.seg, lzb.an, lzb.frame_tick),
            outs(7'h7F, 2'b11, 1'b0));
    end
    chk("tick_count", ticks, 6);

    // Asynchronous reset in the middle of SHOW_TENS
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (bus.an === 2'b01) found = 1'b1;
    end
    chk("find_tens_slot", int'(found), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_main", outs(bus.seg, bus.an, bus.frame_tick),
        outs(7'h7F, 2'b11, 1'b0));
    chk("async_rst_lz", outs(lzb.seg, lzb.an, lzb.frame_tick),
        outs(7'h7F, 2'b11, 1'b0));
    @(negedge clk);
    chk("rst_hold", outs(bus.seg, bus.an, bus.frame_tick),
        outs(7'h7F, 2'b11, 1'b0));
    rst = 1'b0;
    @(negedge clk);
    chk("restart_k1", outs(bus.seg, bus.an, bus.frame_tick),
        outs(7'h7F, 2'b11, 1'b0));
    @(negedge clk);
    chk("restart_k2", outs(bus.seg, bus.an, bus.frame_tick),
        outs(7'h12, 2'b10, 1'b1));
    chk("restart_lz_k2", outs(lzb.seg, lzb.an, lzb.frame_tick),
        outs(7'h12, 2'b10, 1'b1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
